keypad_scanner: RTL and testbench

Upstream input stage for the calculator datapath. Scans a 4x4 matrix keypad by driving one column low at a time and sampling the four row lines. Debounces the result and emits one clean key event (code plus single-cycle valid) per physical press. Its outputs feed the calculator's key decoder; col_o drives the keypad column pins on the bidirectional IO bank.

---
 rtl/keypad_pkg.sv | 21 ++
 rtl/keypad_debounce.sv | 134 +++++++++++++
 rtl/keypad_scanner.sv | 115 +++++++++++
 tb/tb_keypad_scanner.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and sizes for the 4x4 keypad scanner and its debounce FSM.
package keypad_pkg;

  localparam int NUM_ROWS   = 4;
  localparam int NUM_COLS   = 4;
  localparam int KEY_CODE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_PRESSED,
    ST_RELEASING
  } state_e;

  typedef enum logic [1:0] {
    SCAN_NONE,
    SCAN_SINGLE,
    SCAN_MULTI
  } scan_class_e;

endpackage

// File: rtl/keypad_debounce.sv
// Press/release debounce FSM advanced once per completed scan.
// Optional auto-repeat is built only when KEYPAD_REPEAT_EN is defined.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 50
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  scan_done,
  input  scan_class_e           scan_class,
  input  logic [KEY_CODE_W-1:0] scan_code,
  output logic [KEY_CODE_W-1:0] key_code,
  output logic                  key_valid,
  output logic                  key_held
);

  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

  state_e                  state;
  logic [KEY_CODE_W-1:0]   cand;
  logic [CNT_W-1:0]        cnt;
  logic                    single_cand;
  logic                    cnt_last;

  assign single_cand = (scan_class == SCAN_SINGLE) && (scan_code == cand);
  // cnt already holds DEBOUNCE_SCANS-1, so this scan completes the count.
  assign cnt_last    = (cnt == CNT_W'(DEBOUNCE_SCANS - 1));

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_SCANS + 1);
  logic [REP_W-1:0] rep_cnt;
`endif

  // NOTE: all FSM state and outputs use non-blocking assignments so every
  // branch sees the values from before this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cand      <= '0;
      cnt       <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt   <= '0;
`endif
    end else begin
      key_valid <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      if (state != ST_PRESSED) rep_cnt <= '0;
`endif
      if (scan_done) begin
        case (state)
          ST_IDLE: begin
            if (scan_class == SCAN_SINGLE) begin
              cand <= scan_code;
              if (DEBOUNCE_SCANS == 1) begin
                state     <= ST_PRESSED;
                key_code  <= scan_code;
                key_valid <= 1'b1;
                key_held  <= 1'b1;
              end else begin
                cnt   <= CNT_W'(1);
                state <= ST_DEBOUNCE;
              end
            end
          end

          ST_DEBOUNCE: begin
            if (single_cand) begin
              if (cnt_last) begin
                state     <= ST_PRESSED;
                key_code  <= cand;
                key_valid <= 1'b1;
                key_held  <= 1'b1;
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end else if (scan_class == SCAN_SINGLE) begin
              cand <= scan_code;
              cnt  <= CNT_W'(1);
            end else begin
              state <= ST_IDLE;
            end
          end

          ST_PRESSED: begin
            if (scan_class == SCAN_NONE) begin
`ifdef KEYPAD_REPEAT_EN
              rep_cnt <= '0;
`endif
              if (DEBOUNCE_SCANS == 1) begin
                state    <= ST_IDLE;
                key_held <= 1'b0;
              end else begin
                cnt   <= CNT_W'(1);
                state <= ST_RELEASING;
              end
            end
`ifdef KEYPAD_REPEAT_EN
            else if (single_cand) begin
              if (rep_cnt == REP_W'(REPEAT_SCANS - 1)) begin
                rep_cnt   <= '0;
                key_code  <= cand;
                key_valid <= 1'b1;
              end else begin
                rep_cnt <= rep_cnt + REP_W'(1);
              end
            end
`endif
          end

          ST_RELEASING: begin
            if (scan_class == SCAN_NONE) begin
              if (cnt_last) begin
                state    <= ST_IDLE;
                key_held <= 1'b0;
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end else begin
              state <= ST_PRESSED;
            end
          end

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row synchroniser, column strobe, scan classifier.
// Define KEYPAD_REPEAT_EN to enable auto-repeat of a held key.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 50
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_ROWS-1:0]   row_i,
  output logic [NUM_COLS-1:0]   col_o,
  output logic [KEY_CODE_W-1:0] key_code_o,
  output logic                  key_valid_o,
  output logic                  key_held_o
);

  localparam int DIV_W = $clog2(SCAN_DIV);

  logic [NUM_ROWS-1:0] row_meta;
  logic [NUM_ROWS-1:0] row_sync;
  logic [DIV_W-1:0]    div_cnt;
  logic [1:0]          col_idx;
  logic [1:0]          col_next;
  logic                tick;

  // Hits accumulated over the columns already visited in this scan (saturates at 2).
  logic [1:0]            acc_hits;
  logic [KEY_CODE_W-1:0] acc_code;

  logic [2:0]            col_hits;
  logic [1:0]            col_row;
  logic [2:0]            hit_sum;
  logic                  scan_done;
  scan_class_e           scan_class;
  logic [KEY_CODE_W-1:0] scan_code;

  // Rows idle high through pull-ups, so the synchroniser resets to "no key".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta <= '1;
      row_sync <= '1;
    end else begin
      row_meta <= row_i;
      row_sync <= row_meta;
    end
  end

  assign tick     = (div_cnt == DIV_W'(SCAN_DIV - 1));
  assign col_next = col_idx + 2'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      col_idx <= '0;
      col_o   <= 4'b1110;
    end else if (tick) begin
      div_cnt <= '0;
      col_idx <= col_next;
      col_o   <= ~(4'b0001 << col_next);
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // NOTE: every variable assigned here gets a default first, so no latch is inferred.
  always_comb begin
    col_hits = '0;
    col_row  = '0;
    for (int r = NUM_ROWS - 1; r >= 0; r--) begin
      if (!row_sync[r]) begin
        col_hits = col_hits + 3'd1;
        col_row  = 2'(r);
      end
    end
    hit_sum   = {1'b0, acc_hits} + col_hits;
    scan_code = (acc_hits != 2'd0) ? acc_code : {col_row, col_idx};
    if (hit_sum == 3'd0)      scan_class = SCAN_NONE;
    else if (hit_sum == 3'd1) scan_class = SCAN_SINGLE;
    else                      scan_class = SCAN_MULTI;
  end

  assign scan_done = tick && (col_idx == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_hits <= '0;
      acc_code <= '0;
    end else if (tick) begin
      if (scan_done) begin
        acc_hits <= '0;
        acc_code <= '0;
      end else begin
        acc_hits <= (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
        acc_code <= scan_code;
      end
    end
  end

  keypad_debounce #(
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS),
    .REPEAT_SCANS   (REPEAT_SCANS)
  ) u_debounce (
    .clk        (clk),
    .rst_n      (rst_n),
    .scan_done  (scan_done),
    .scan_class (scan_class),
    .scan_code  (scan_code),
    .key_code   (key_code_o),
    .key_valid  (key_valid_o),
    .key_held   (key_held_o)
  );

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural keypad matrix and a
// scoreboard of expected key codes. Honours KEYPAD_REPEAT_EN when defined.
module tb_keypad_scanner;

  localparam int SCAN_CYC = 16;  // 4 columns x SCAN_DIV(4)
`ifdef KEYPAD_REPEAT_EN
  localparam int EXP_REPEATS = 4;
`else
  localparam int EXP_REPEATS = 0;
`endif

  logic       clk;
  logic       rst_n;
  logic [3:0] row_i;
  logic [3:0] col_o;
  logic [3:0] key_code_o;
  logic       key_valid_o;
  logic       key_held_o;

  logic [15:0] keys;
  logic [3:0]  exp_q[$];

  int passed, total, failed;
  int cyc, boundary_cyc, valid_cyc, pulse_count, base, t0;
  logic held_at_valid, held_before_valid, prev_valid, prev_held;

  keypad_scanner #(
    .SCAN_DIV       (4),
    .DEBOUNCE_SCANS (3),
    .REPEAT_SCANS   (5)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .row_i       (row_i),
    .col_o       (col_o),
    .key_code_o  (key_code_o),
    .key_valid_o (key_valid_o),
    .key_held_o  (key_held_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Matrix model: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row_i = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_o[c]) row_i[r] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Returns #1 after the negedge following the n-th scan-completion edge.
  task automatic wait_scans(input int n);
    logic [3:0] prev;
    bit got;
    for (int i = 0; i < n; i++) begin
      prev = col_o;
      got  = 1'b0;
      for (int g = 0; g < 4 * SCAN_CYC && !got; g++) begin
        @(negedge clk);
        if (prev == 4'b0111 && col_o == 4'b1110) got = 1'b1;
        prev = col_o;
      end
      if (!got) check("scan_timeout", {31'b0, got}, 32'd1);
      boundary_cyc = cyc;
    end
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && key_valid_o) begin
      pulse_count++;
      valid_cyc         = cyc;
      held_at_valid     = key_held_o;
      held_before_valid = prev_held;
      check("valid_width", {31'b0, prev_valid}, 32'd0);
      if (exp_q.size() == 0) check("spurious_valid", {31'b0, key_valid_o}, 32'd0);
      else check("key_code", {28'b0, key_code_o}, {28'b0, exp_q.pop_front()});
    end
    prev_valid = key_valid_o;
    prev_held  = key_held_o;
  end

  initial begin
    passed = 0; total = 0; failed = 0; pulse_count = 0;
    prev_valid = 1'b0; prev_held = 1'b0;
    keys  = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_col", {28'b0, col_o}, 32'hE);
    check("rst_code", {28'b0, key_code_o}, 32'd0);
    check("rst_valid", {31'b0, key_valid_o}, 32'd0);
    check("rst_held", {31'b0, key_held_o}, 32'd0);
    rst_n = 1'b1;

    // Steady press of key 9 (row 2, col 1) starting on a scan boundary.
    wait_scans(1);
    t0   = boundary_cyc;
    base = pulse_count;
    exp_q.push_back(4'd9);
    keys = 16'h0001 << 9;
    wait_scans(3);
    check("press_pulses", pulse_count - base, 32'd1);
    check("press_latency", valid_cyc - t0, 32'd48);
    check("held_with_valid", {31'b0, held_at_valid}, 32'd1);
    check("held_before_valid", {31'b0, held_before_valid}, 32'd0);
    wait_scans(1);
    check("hold_no_repulse", pulse_count - base, 32'd1);

    // Release with a one-scan re-press glitch while releasing.
    keys = '0;
    wait_scans(1);
    keys = 16'h0001 << 9;
    wait_scans(1);
    keys = '0;
    wait_scans(2);
    check("held_mid_release", {31'b0, key_held_o}, 32'd1);
    wait_scans(1);
    check("held_released", {31'b0, key_held_o}, 32'd0);
    check("glitch_pulses", pulse_count - base, 32'd1);

    // Bounce on key 5: 2 scans on, 1 off, 2 on, then off.
    base = pulse_count;
    keys = 16'h0001 << 5; wait_scans(2);
    keys = '0;            wait_scans(1);
    keys = 16'h0001 << 5; wait_scans(2);
    keys = '0;            wait_scans(3);
    check("bounce_pulses", pulse_count - base, 32'd0);
    check("bounce_held", {31'b0, key_held_o}, 32'd0);
    check("bounce_code", {28'b0, key_code_o}, 32'd9);

    // Keys 0 and 15 together: MULTI, never accepted.
    base = pulse_count;
    keys = 16'h8001;
    wait_scans(10);
    check("multi_pulses", pulse_count - base, 32'd0);
    check("multi_code", {28'b0, key_code_o}, 32'd9);
    check("multi_held", {31'b0, key_held_o}, 32'd0);
    keys = '0;
    wait_scans(3);

    // Reset while debouncing key 6 (cnt=2); key stays down across reset.
    base = pulse_count;
    keys = 16'h0001 << 6;
    wait_scans(2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_col", {28'b0, col_o}, 32'hE);
    check("midrst_code", {28'b0, key_code_o}, 32'd0);
    check("midrst_valid", {31'b0, key_valid_o}, 32'd0);
    check("midrst_held", {31'b0, key_held_o}, 32'd0);
    repeat (2) @(negedge clk);
    exp_q.push_back(4'd6);
    rst_n = 1'b1;
    wait_scans(2);
    check("postrst_no_early", pulse_count - base, 32'd0);
    wait_scans(1);
    check("postrst_pulse", pulse_count - base, 32'd1);
    check("postrst_held", {31'b0, key_held_o}, 32'd1);
    keys = '0;
    wait_scans(3);

    // Key 12 held for 20 scans past acceptance (repeats only when enabled).
    base = pulse_count;
    for (int i = 0; i < 1 + EXP_REPEATS; i++) exp_q.push_back(4'd12);
    keys = 16'h0001 << 12;
    wait_scans(3);
    wait_scans(20);
    check("repeat_pulses", pulse_count - base, 32'(1 + EXP_REPEATS));
    check("repeat_code", {28'b0, key_code_o}, 32'd12);
    keys = '0;
    wait_scans(3);
    check("final_held", {31'b0, key_held_o}, 32'd0);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
